// File: rtl/nts_api_pkg.sv
// Shared definitions for the NTS engine register API host bridge: state encodings,
// API bus widths and pipeline latency.
package nts_api_pkg;

  localparam int unsigned NTS_API_ADDR_W           = 12;
  localparam int unsigned NTS_API_DATA_W           = 32;
  // Cycles from i_external_api_cs to o_external_api_read_data_valid.
  localparam int unsigned NTS_API_PIPELINE_LATENCY = 4;

  typedef enum logic [1:0] {
    BRIDGE_IDLE  = 2'd0,
    BRIDGE_ISSUE = 2'd1,
    BRIDGE_WAIT  = 2'd2,
    BRIDGE_RESP  = 2'd3
  } bridge_state_e;

endpackage

// File: rtl/nts_api_host_bridge_timer.sv
// Watchdog counter for the host bridge: clears on request, counts while enabled and
// flags expiry when the count reaches LIMIT-1.
module nts_api_host_bridge_timer #(
  parameter logic [7:0] LIMIT = 8'd16
) (
  input  logic i_clk,
  input  logic i_areset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = 8'd0;
    end else if (i_enable) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expired = (count_q == (LIMIT - 8'd1));

endmodule

// File: rtl/nts_api_host_bridge.sv
// Host valid/ready front end for the NTS engine register API; one transaction in flight.
// Optional watchdog abort is enabled with `define NTS_API_HOST_BRIDGE_TIMEOUT_EN.
module nts_api_host_bridge
  import nts_api_pkg::*;
#(
  parameter logic [NTS_API_ADDR_W-1:0] ADDR_LIMIT     = 12'h2FF,
  parameter logic [7:0]                TIMEOUT_CYCLES = 8'd16
) (
  input  logic                      i_clk,
  input  logic                      i_areset,
  input  logic                      i_host_req,
  input  logic                      i_host_we,
  input  logic [NTS_API_ADDR_W-1:0] i_host_address,
  input  logic [NTS_API_DATA_W-1:0] i_host_write_data,
  output logic                      o_host_ready,
  output logic                      o_host_ack,
  output logic [NTS_API_DATA_W-1:0] o_host_read_data,
  output logic                      o_host_error,
  output logic                      o_api_cs,
  output logic                      o_api_we,
  output logic [NTS_API_ADDR_W-1:0] o_api_address,
  output logic [NTS_API_DATA_W-1:0] o_api_write_data,
  input  logic                      i_api_busy,
  input  logic [NTS_API_DATA_W-1:0] i_api_read_data,
  input  logic                      i_api_read_data_valid
);

  bridge_state_e             state_q, state_d;
  logic                      cs_q, cs_d;
  logic                      we_q, we_d;
  logic [NTS_API_ADDR_W-1:0] addr_q, addr_d;
  logic [NTS_API_DATA_W-1:0] wdata_q, wdata_d;
  logic                      ack_q, ack_d;
  logic [NTS_API_DATA_W-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      accept;
  logic                      timeout;

  assign o_host_ready = (state_q == BRIDGE_IDLE) && !i_api_busy;
  assign accept       = i_host_req && o_host_ready;

`ifdef NTS_API_HOST_BRIDGE_TIMEOUT_EN
  logic timer_expired;

  nts_api_host_bridge_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk     (i_clk),
    .i_areset  (i_areset),
    .i_clear   (state_q == BRIDGE_ISSUE),
    .i_enable  ((state_q == BRIDGE_WAIT) && !i_api_read_data_valid),
    .o_expired (timer_expired)
  );

  assign timeout = timer_expired;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // The response is registered on the deciding edge, so a normal completion returns
  // straight to IDLE and the ack cycle overlaps ready. Locally generated error acks
  // (range reject, timeout) spend that ack cycle in RESP.
  always_comb begin
    state_d = state_q;
    cs_d    = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    rdata_d = '0;
    err_d   = 1'b0;
    unique case (state_q)
      BRIDGE_IDLE: begin
        if (accept) begin
          we_d    = i_host_we;
          addr_d  = i_host_address;
          wdata_d = i_host_write_data;
          if (i_host_address > ADDR_LIMIT) begin
            state_d = BRIDGE_RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = BRIDGE_ISSUE;
            cs_d    = 1'b1;
          end
        end
      end
      BRIDGE_ISSUE: begin
        state_d = BRIDGE_WAIT;
      end
      BRIDGE_WAIT: begin
        if (i_api_read_data_valid) begin
          state_d = BRIDGE_IDLE;
          ack_d   = 1'b1;
          rdata_d = we_q ? '0 : i_api_read_data;
        end else if (timeout) begin
          state_d = BRIDGE_RESP;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end
      end
      BRIDGE_RESP: begin
        state_d = BRIDGE_IDLE;
      end
      default: begin
        state_d = BRIDGE_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q <= BRIDGE_IDLE;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign o_api_cs         = cs_q;
  assign o_api_we         = we_q;
  assign o_api_address    = addr_q;
  assign o_api_write_data = wdata_q;
  assign o_host_ack       = ack_q;
  assign o_host_read_data = rdata_q;
  assign o_host_error     = err_q;

endmodule
